// File: rtl/fifo_loopback_engine_pkg.sv
// Shared state and error encodings for the FIFO loopback engine.
package fifo_loopback_engine_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_WRITE  = 4'd2,
    ST_READ   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_CHECK  = 4'd5,
    ST_ERROR  = 4'd6,
    ST_FINISH = 4'd7
  } st_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_WR_TMO   = 2'd2,
    ERR_RD_TMO   = 2'd3
  } err_t;

endpackage

// File: rtl/fifo_loopback_engine_if.sv
// FIFO write/read port bundle between the loopback engine (master) and the FIFO under test (slave).
interface fifo_loopback_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, rd_data, rd_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, rd_data, rd_empty
  );
endinterface

// File: rtl/fifo_loopback_engine_pattern_gen.sv
// Word pattern generator: incrementing counter or right-shifting Galois LFSR, both seeded with SEED.
module pattern_gen #(
  parameter int unsigned        DATA_W = 8,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'(1),
  parameter logic [DATA_W-1:0]  TAPS   = DATA_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic              mode,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] lfsr_nxt;

  always_comb begin
    lfsr_nxt = value >> 1;
    if (value[0]) lfsr_nxt = lfsr_nxt ^ TAPS;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      value <= '0;
    else if (init)
      value <= SEED;
    else if (step)
      value <= mode ? lfsr_nxt : value + DATA_W'(1);
  end

endmodule

// File: rtl/fifo_loopback_engine.sv
// FIFO loopback test engine: writes a generated burst, reads it back and checks each word
// against a second, identically seeded generator; reports first failure and progress.
module fifo_loopback_engine
  import fifo_loopback_engine_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       LEN_W   = 8,
  parameter int unsigned       TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(1),
  parameter logic [DATA_W-1:0] TAPS    = DATA_W'(8'hB8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LEN_W-1:0]     burst_len,
  output logic                 active,
  output st_t                  st,
  output logic                 done,
  output logic                 error,
  output err_t                 err_code,
  output logic [LEN_W-1:0]     err_index,
  output logic [DATA_W-1:0]    err_data,
  fifo_loopback_engine_if.master bus
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  st_t               st_nxt;
  logic              mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [STALL_W-1:0] stall;
  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] exp_val;
  logic              wr_fire;
  logic              rd_fire;
  logic              stalled;
  logic              tmo;
  logic              mism;
  logic              last;
  logic              gen_init;
  logic              exp_step;

  always_comb begin
    stalled  = (st == ST_WRITE && bus.wr_full) || (st == ST_READ && bus.rd_empty);
    tmo      = stalled && (stall == STALL_W'(TIMEOUT - 1));
    mism     = (st == ST_CHECK) && (bus.rd_data != exp_val);
    last     = (cnt == len_q - LEN_W'(1));
    gen_init = (st == ST_START);
    exp_step = (st == ST_CHECK) && !mism;
  end

  pattern_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_wr_gen (
    .clk   (clk),
    .rst   (rst),
    .init  (gen_init),
    .step  (wr_fire),
    .mode  (mode_q),
    .value (wr_val)
  );

  pattern_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_exp_gen (
    .clk   (clk),
    .rst   (rst),
    .init  (gen_init),
    .step  (exp_step),
    .mode  (mode_q),
    .value (exp_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) st <= ST_IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:   if (start) st_nxt = ST_START;
      ST_START:  st_nxt = (len_q == '0) ? ST_FINISH : ST_WRITE;
      ST_WRITE: begin
        if (tmo)                 st_nxt = ST_ERROR;
        else if (wr_fire && last) st_nxt = ST_READ;
      end
      ST_READ: begin
        if (tmo)          st_nxt = ST_ERROR;
        else if (rd_fire) st_nxt = ST_WAIT;
      end
      ST_WAIT:   st_nxt = ST_CHECK;
      ST_CHECK: begin
        if (mism)      st_nxt = ST_ERROR;
        else if (last) st_nxt = ST_FINISH;
        else           st_nxt = ST_READ;
      end
      ST_ERROR:  if (!start) st_nxt = ST_IDLE;
      ST_FINISH: st_nxt = ST_IDLE;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    active      = (st != ST_IDLE);
    done        = (st == ST_FINISH);
    wr_fire     = (st == ST_WRITE) && !bus.wr_full;
    rd_fire     = (st == ST_READ) && !bus.rd_empty;
    bus.wr_en   = wr_fire;
    bus.rd_en   = rd_fire;
    bus.wr_data = wr_val;
  end

  // One word counter serves both phases: it restarts when the last word is written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      stall     <= '0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      err_index <= '0;
      err_data  <= '0;
    end else begin
      if (st_nxt != st || !stalled) stall <= '0;
      else                          stall <= stall + STALL_W'(1);

      case (st)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            len_q     <= burst_len;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
            err_data  <= '0;
          end
        end
        ST_START: cnt <= '0;
        ST_WRITE: begin
          if (wr_fire) cnt <= last ? '0 : cnt + LEN_W'(1);
        end
        ST_CHECK: begin
          if (mism) begin
            error     <= 1'b1;
            err_code  <= ERR_MISMATCH;
            err_index <= cnt;
            err_data  <= bus.rd_data;
          end else if (!last) begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase

      if (tmo) begin
        error     <= 1'b1;
        err_code  <= (st == ST_WRITE) ? ERR_WR_TMO : ERR_RD_TMO;
        err_index <= cnt;
        err_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_loopback_engine.sv
// Directed bench for fifo_loopback_engine with a behavioural FIFO of adjustable depth.
module tb_fifo_loopback_engine;
  import fifo_loopback_engine_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] burst_len;
  logic       active;
  st_t        st;
  logic       done;
  logic       error;
  err_t       err_code;
  logic [7:0] err_index;
  logic [7:0] err_data;

  int total = 0;
  int bad   = 0;

  fifo_loopback_engine_if #(.DATA_W(8)) bus ();

  fifo_loopback_engine #(
    .DATA_W  (8),
    .LEN_W   (8),
    .TIMEOUT (1024),
    .SEED    (8'h01),
    .TAPS    (8'hB8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .burst_len (burst_len),
    .active    (active),
    .st        (st),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .err_index (err_index),
    .err_data  (err_data),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with a registered read port and optional corruption of one read.
  int         depth      = 16;
  int         corrupt_at = -1;
  logic       flush      = 1'b0;
  logic [7:0] mem  [0:63];
  logic [7:0] wlog [0:63];
  int         wp = 0, rp = 0, fcnt = 0, wn = 0, nwr = 0, nrd = 0;
  logic [7:0] rdq = 8'h00;

  assign bus.wr_full  = (fcnt >= depth);
  assign bus.rd_empty = (fcnt == 0);
  assign bus.rd_data  = rdq;

  always @(posedge clk) begin
    if (flush) begin
      rp   <= wp;
      fcnt <= 0;
    end else begin
      if (bus.wr_en) begin
        mem[wp % 64]  <= bus.wr_data;
        wlog[wn % 64] <= bus.wr_data;
        wn  <= wn + 1;
        wp  <= wp + 1;
        nwr <= nwr + 1;
      end
      if (bus.rd_en) begin
        rdq <= (nrd == corrupt_at) ? 8'hFF : mem[rp % 64];
        rp  <= rp + 1;
        nrd <= nrd + 1;
      end
      fcnt <= fcnt + (bus.wr_en ? 1 : 0) - (bus.rd_en ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic m, input logic [7:0] len);
    start     = 1'b1;
    mode      = m;
    burst_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Follows a run from the START cycle until it settles in IDLE or ERROR.
  task automatic wait_stop(output int cyc, output int ndone, output int nstall,
                           output int nviol, output logic hit);
    cyc = 1; ndone = 0; nstall = 0; nviol = 0; hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) ndone++;
      if (st == ST_WRITE && bus.wr_full) nstall++;
      if ((bus.wr_en && bus.wr_full) || (bus.rd_en && bus.rd_empty)) nviol++;
      if (i > 0 && (st == ST_IDLE || st == ST_ERROR)) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    int   cyc, nd, ns, nv, base, wr0, rd0;
    logic hit;

    rst = 1'b0; start = 1'b0; mode = 1'b0; burst_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st",      32'(st), 32'(ST_IDLE));
    chk("rst_active",  32'(active), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_error",   32'(error), 32'd0);
    chk("rst_code",    32'(err_code), 32'(ERR_NONE));
    chk("rst_wr_en",   32'(bus.wr_en), 32'd0);
    chk("rst_rd_en",   32'(bus.rd_en), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Incrementing pattern, ideal FIFO
    base = wn; rd0 = nrd;
    launch(1'b0, 8'd4);
    chk("t1_start_st", 32'(st), 32'(ST_START));
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t1_hit",    32'(hit), 32'd1);
    chk("t1_cycles", 32'(cyc), 32'd19);
    chk("t1_done",   32'(nd), 32'd1);
    chk("t1_error",  32'(error), 32'd0);
    chk("t1_code",   32'(err_code), 32'(ERR_NONE));
    chk("t1_w0",     32'(wlog[base]),     32'h01);
    chk("t1_w1",     32'(wlog[base + 1]), 32'h02);
    chk("t1_w2",     32'(wlog[base + 2]), 32'h03);
    chk("t1_w3",     32'(wlog[base + 3]), 32'h04);
    chk("t1_nrd",    32'(nrd - rd0), 32'd4);
    chk("t1_viol",   32'(nv), 32'd0);

    // LFSR pattern
    base = wn;
    launch(1'b1, 8'd3);
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t2_hit",    32'(hit), 32'd1);
    chk("t2_cycles", 32'(cyc), 32'd15);
    chk("t2_done",   32'(nd), 32'd1);
    chk("t2_error",  32'(error), 32'd0);
    chk("t2_w0",     32'(wlog[base]),     32'h01);
    chk("t2_w1",     32'(wlog[base + 1]), 32'hB8);
    chk("t2_w2",     32'(wlog[base + 2]), 32'h5C);

    // Third read word corrupted
    corrupt_at = nrd + 2;
    launch(1'b0, 8'd4);
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t3_hit",    32'(hit), 32'd1);
    chk("t3_st",     32'(st), 32'(ST_ERROR));
    chk("t3_error",  32'(error), 32'd1);
    chk("t3_code",   32'(err_code), 32'(ERR_MISMATCH));
    chk("t3_index",  32'(err_index), 32'd2);
    chk("t3_data",   32'(err_data), 32'hFF);
    chk("t3_done",   32'(nd), 32'd0);
    chk("t3_err_rd_en", 32'(bus.rd_en), 32'd0);
    corrupt_at = -1;
    do_flush();
    chk("t3_idle",       32'(st), 32'(ST_IDLE));
    chk("t3_err_sticky", 32'(error), 32'd1);

    // Write-side stall: shallow FIFO never drained
    depth = 2;
    launch(1'b0, 8'd5);
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t4_hit",    32'(hit), 32'd1);
    chk("t4_st",     32'(st), 32'(ST_ERROR));
    chk("t4_stall",  32'(ns), 32'd1024);
    chk("t4_code",   32'(err_code), 32'(ERR_WR_TMO));
    chk("t4_index",  32'(err_index), 32'd2);
    chk("t4_data",   32'(err_data), 32'd0);
    chk("t4_viol",   32'(nv), 32'd0);
    chk("t4_done",   32'(nd), 32'd0);
    do_flush();
    depth = 16;

    // Zero-length burst
    wr0 = nwr; rd0 = nrd;
    launch(1'b0, 8'd0);
    chk("t5_err_clr", 32'(error), 32'd0);
    chk("t5_code_clr", 32'(err_code), 32'(ERR_NONE));
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t5_hit",    32'(hit), 32'd1);
    chk("t5_cycles", 32'(cyc), 32'd3);
    chk("t5_done",   32'(nd), 32'd1);
    chk("t5_nwr",    32'(nwr - wr0), 32'd0);
    chk("t5_nrd",    32'(nrd - rd0), 32'd0);

    // Reset in the middle of WRITE with start held high
    start = 1'b1; mode = 1'b0; burst_len = 8'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_in_write", 32'(st), 32'(ST_WRITE));
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_st",      32'(st), 32'(ST_IDLE));
    chk("t6_active",  32'(active), 32'd0);
    chk("t6_wr_en",   32'(bus.wr_en), 32'd0);
    chk("t6_rd_en",   32'(bus.rd_en), 32'd0);
    chk("t6_wr_data", 32'(bus.wr_data), 32'd0);
    chk("t6_error",   32'(error), 32'd0);
    chk("t6_index",   32'(err_index), 32'd0);
    chk("t6_done",    32'(done), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_restart", 32'(st), 32'(ST_START));
    wait_stop(cyc, nd, ns, nv, hit);
    chk("t6_hit",    32'(hit), 32'd1);
    chk("t6_cycles", 32'(cyc), 32'd23);
    chk("t6_rdone",  32'(nd), 32'd1);
    chk("t6_rerror", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
